// File: rtl/mem_lsu_if.sv
// mem_lsu_if: handshaked data-memory bus between the load/store unit and memory.
interface mem_lsu_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              memread;
    logic              memwrite;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;

    modport master (output addr, memread, memwrite, be, wdata, input rdata, ready);
    modport slave  (input addr, memread, memwrite, be, wdata, output rdata, ready);
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with byte lanes, wait states, stall and error reporting.
module mem_lsu #(
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT    = 16,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err,
    mem_lsu_if.master         mem
);
    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          we_q, sgn_q;
    logic [1:0]    size_q;
    logic          misaligned;
    logic [1:0]    lane;
    logic [3:0]    be_n;
    logic [31:0]   wdata_n;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;

    assign misaligned = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) |
                        (req_size == 2'b10 & |req_addr[1:0]);
    // Big-endian mirrors the lane index; half selection then falls out of lane[1].
    assign lane    = (BIG_ENDIAN != 0) ? ~req_addr[1:0] : req_addr[1:0];
    assign be_n    = req_size == 2'b00 ? 4'b0001 << lane :
                     req_size == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_n = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                     req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;

    assign byte_sel  = mem.be[3] ? mem.rdata[31:24] : mem.be[2] ? mem.rdata[23:16] :
                       mem.be[1] ? mem.rdata[15:8] : mem.rdata[7:0];
    assign half_sel  = mem.be[3] ? mem.rdata[31:16] : mem.rdata[15:0];
    assign load_data = size_q == 2'b10 ? mem.rdata :
                       size_q == 2'b01 ? {{16{sgn_q & half_sel[15]}}, half_sel} :
                                         {{24{sgn_q & byte_sel[7]}}, byte_sel};

    assign stall = rst_n & ((state == IDLE & req_valid) | state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            we_q         <= 1'b0;
            sgn_q        <= 1'b0;
            size_q       <= 2'b00;
            mem.addr     <= '0;
            mem.memread  <= 1'b0;
            mem.memwrite <= 1'b0;
            mem.be       <= 4'b0000;
            mem.wdata    <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 2'b00;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q   <= req_we;
                    sgn_q  <= req_signed;
                    size_q <= req_size;
                    if (misaligned) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 2'b01;
                    end else begin
                        state        <= BUSY;
                        cnt          <= '0;
                        mem.addr     <= {req_addr[ADDR_W-1:2], 2'b00};
                        mem.memread  <= ~req_we;
                        mem.memwrite <= req_we;
                        mem.be       <= be_n;
                        mem.wdata    <= wdata_n;
                    end
                end
                BUSY: if (mem.ready) begin
                    state        <= DONE;
                    mem.memread  <= 1'b0;
                    mem.memwrite <= 1'b0;
                    resp_valid   <= 1'b1;
                    resp_rdata   <= we_q ? 32'h0 : load_data;
                    resp_err     <= 2'b00;
                end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
                    state        <= DONE;
                    mem.memread  <= 1'b0;
                    mem.memwrite <= 1'b0;
                    resp_valid   <= 1'b1;
                    resp_rdata   <= 32'h0;
                    resp_err     <= 2'b10;
                end else if (TIMEOUT != 0) begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and randomized checks of mem_lsu against a byte-level memory model.
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall0, stall1, rv0, rv1;
    logic [31:0] rd0, rd1;
    logic [1:0]  err0, err1;
    bit          sel;

    logic        o_stall, o_rv, o_mr, o_mw;
    logic [31:0] o_rd, o_wd, o_ad;
    logic [1:0]  o_err;
    logic [3:0]  o_be;

    logic [3:0]  ob_be;
    logic [31:0] ob_wd, ob_ad, ob_rd;
    logic [1:0]  ob_err, ob_kind;
    int          ob_lat, ob_strobes, ob_strobe_cyc, ob_stall_cyc, ob_overlap;
    int          checks = 0, errors = 0;

    mem_lsu_if #(.ADDR_W(32)) bus0 ();
    mem_lsu_if #(.ADDR_W(32)) bus1 ();

    mem_lsu #(.ADDR_W(32), .TIMEOUT(4), .BIG_ENDIAN(0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall0),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0), .mem(bus0.master));

    mem_lsu #(.ADDR_W(32), .TIMEOUT(16), .BIG_ENDIAN(1)) dut_be (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall1),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1), .mem(bus1.master));

    always #5 clk = ~clk;

    always_comb begin
        o_stall = sel ? stall1 : stall0;
        o_rv    = sel ? rv1 : rv0;
        o_rd    = sel ? rd1 : rd0;
        o_err   = sel ? err1 : err0;
        o_mr    = sel ? bus1.memread : bus0.memread;
        o_mw    = sel ? bus1.memwrite : bus0.memwrite;
        o_be    = sel ? bus1.be : bus0.be;
        o_wd    = sel ? bus1.wdata : bus0.wdata;
        o_ad    = sel ? bus1.addr : bus0.addr;
    end

    // Memory seen as bytes: value byte k lives at address a+i, mapped to a lane by endianness.
    function automatic void model(input logic we, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, wd, rd, input bit big,
                                  output logic [3:0] e_be, output logic [31:0] e_wd, e_rd,
                                  output logic [1:0] e_err);
        int nb = 1 << sz;
        logic [31:0] v = 32'h0;
        e_be = 4'b0; e_wd = 32'h0; e_rd = 32'h0;
        if (sz == 2'b11 || (a % nb) != 0) begin
            e_err = 2'b01;
            return;
        end
        e_err = 2'b00;
        for (int i = 0; i < nb; i++) begin
            int n = int'(a % 4) + i;
            int l = big ? 3 - n : n;
            int k = big ? nb - 1 - i : i;
            e_be[l] = 1'b1;
            e_wd[8*l +: 8] = wd[8*k +: 8];
            v[8*k +: 8] = rd[8*l +: 8];
        end
        if (sg && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
        e_rd = we ? 32'h0 : v;
    endfunction

    task automatic drive_mem(input logic r, input logic [31:0] d);
        bus0.ready = r; bus1.ready = r;
        bus0.rdata = d; bus1.rdata = d;
    endtask

    // Presents one request, plays the memory (ready after `waits` BUSY cycles), returns in DONE.
    task automatic run_access(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, wd, rd, input int waits);
        int busy = 0;
        logic prev = 1'b0;
        logic r;
        ob_be = 4'b0; ob_wd = 32'h0; ob_ad = 32'h0; ob_rd = 32'hDEADBEEF; ob_err = 2'b11;
        ob_kind = 2'b00; ob_lat = -1; ob_strobes = 0; ob_strobe_cyc = 0; ob_stall_cyc = 0;
        ob_overlap = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (o_stall) ob_stall_cyc++;
            if (o_mr && o_mw) ob_overlap++;
            if ((o_mr || o_mw) && !prev) ob_strobes++;
            prev = o_mr | o_mw;
            if (prev) begin
                ob_strobe_cyc++;
                ob_be = o_be; ob_wd = o_wd; ob_ad = o_ad; ob_kind = {o_mw, o_mr};
                r = (busy == waits);
                busy++;
            end else begin
                r = 1'($urandom_range(0, 1));
            end
            drive_mem(r, r ? rd : $urandom);
            if (o_rv) begin
                ob_lat = c; ob_rd = o_rd; ob_err = o_err;
                break;
            end
            @(negedge clk); #1;
        end
        req_valid = 1'b0;
        drive_mem(1'b0, 32'h0);
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({stall0, rv0, rd0, err0, bus0.memread, bus0.memwrite, bus0.be, bus0.addr} !== '0) begin
            errors++;
            $display("FAIL reset_le got stall=%b rv=%b rd=%h err=%b mr=%b mw=%b be=%b ad=%h exp all 0",
                     stall0, rv0, rd0, err0, bus0.memread, bus0.memwrite, bus0.be, bus0.addr);
        end
        checks++;
        if ({stall1, rv1, rd1, err1, bus1.memread, bus1.memwrite, bus1.be, bus1.addr} !== '0) begin
            errors++;
            $display("FAIL reset_be got stall=%b rv=%b rd=%h err=%b exp all 0", stall1, rv1, rd1, err1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lb_signed;
        sel = 1'b0;
        run_access(1'b0, 2'b00, 1'b1, 32'h103, $urandom, 32'h80FF_1234, 0);
        checks++; if (ob_be !== 4'b1000) begin errors++; $display("FAIL lb_be got %b exp 1000", ob_be); end
        checks++; if (ob_ad !== 32'h100) begin errors++; $display("FAIL lb_addr got %h exp 00000100", ob_ad); end
        checks++; if (ob_rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", ob_rd); end
        checks++; if (ob_lat !== 2) begin errors++; $display("FAIL lb_latency got %0d exp 2", ob_lat); end
        checks++; if (ob_kind !== 2'b01) begin errors++; $display("FAIL lb_strobe got %b exp 01", ob_kind); end
    endtask

    task automatic test_sh_waits;
        sel = 1'b0;
        run_access(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, $urandom, 3);
        checks++; if (ob_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", ob_be); end
        checks++; if (ob_wd !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got %h exp beefbeef", ob_wd); end
        checks++; if (ob_stall_cyc !== 5) begin errors++; $display("FAIL sh_stall got %0d exp 5", ob_stall_cyc); end
        checks++; if (ob_err !== 2'b00) begin errors++; $display("FAIL sh_err got %b exp 00", ob_err); end
        checks++; if (ob_rd !== 32'h0) begin errors++; $display("FAIL sh_rdata got %h exp 0", ob_rd); end
    endtask

    task automatic test_misaligned;
        sel = 1'b0;
        run_access(1'b0, 2'b10, 1'b0, 32'h41, $urandom, $urandom, 0);
        checks++; if (ob_strobes !== 0) begin errors++; $display("FAIL lw_mis_strobe got %0d exp 0", ob_strobes); end
        checks++; if (ob_err !== 2'b01) begin errors++; $display("FAIL lw_mis_err got %b exp 01", ob_err); end
        checks++; if (ob_lat !== 1) begin errors++; $display("FAIL lw_mis_latency got %0d exp 1", ob_lat); end
        checks++; if (ob_rd !== 32'h0) begin errors++; $display("FAIL lw_mis_rdata got %h exp 0", ob_rd); end
        run_access(1'b1, 2'b11, 1'b0, 32'h40, $urandom, $urandom, 0);
        checks++; if (ob_err !== 2'b01) begin errors++; $display("FAIL size11_err got %b exp 01", ob_err); end
        checks++; if (ob_strobes !== 0) begin errors++; $display("FAIL size11_strobe got %0d exp 0", ob_strobes); end
    endtask

    task automatic test_timeout;
        sel = 1'b0;
        run_access(1'b0, 2'b10, 1'b0, 32'h80, $urandom, $urandom, 99);
        checks++; if (ob_strobe_cyc !== 4) begin errors++; $display("FAIL to_busy_cycles got %0d exp 4", ob_strobe_cyc); end
        checks++; if (ob_err !== 2'b10) begin errors++; $display("FAIL to_err got %b exp 10", ob_err); end
        checks++; if (ob_rd !== 32'h0) begin errors++; $display("FAIL to_rdata got %h exp 0", ob_rd); end
        checks++; if (ob_lat !== 5) begin errors++; $display("FAIL to_latency got %0d exp 5", ob_lat); end
        run_access(1'b0, 2'b10, 1'b0, 32'h10, $urandom, 32'h1234_5678, 1);
        checks++; if (ob_err !== 2'b00) begin errors++; $display("FAIL to_next_err got %b exp 00", ob_err); end
        checks++; if (ob_rd !== 32'h1234_5678) begin errors++; $display("FAIL to_next_rdata got %h exp 12345678", ob_rd); end
    endtask

    task automatic test_async_reset;
        bit saw_rv = 1'b0;
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b01; req_signed = 1'b0;
        req_addr = 32'h8002; req_wdata = 32'h0;
        drive_mem(1'b0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus0.memread !== 1'b1) begin errors++; $display("FAIL ar_busy_strobe got %b exp 1", bus0.memread); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus0.memread, bus0.memwrite, stall0, bus1.memread, stall1} !== 5'b0) begin
            errors++;
            $display("FAIL ar_drop got mr=%b mw=%b stall=%b mr_be=%b stall_be=%b exp 0",
                     bus0.memread, bus0.memwrite, stall0, bus1.memread, stall1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (rv0 || rv1) saw_rv = 1'b1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        if (rv0 || rv1) saw_rv = 1'b1;
        checks++; if (saw_rv !== 1'b0) begin errors++; $display("FAIL ar_no_resp got %b exp 0", saw_rv); end
        run_access(1'b0, 2'b01, 1'b0, 32'h8002, $urandom, 32'hF00D_0000, 1);
        checks++; if (ob_rd !== 32'h0000_F00D) begin errors++; $display("FAIL ar_lhu_rdata got %h exp 0000f00d", ob_rd); end
        checks++; if (ob_err !== 2'b00) begin errors++; $display("FAIL ar_lhu_err got %b exp 00", ob_err); end
    endtask

    task automatic test_big_endian;
        sel = 1'b1;
        run_access(1'b1, 2'b00, 1'b0, 32'h0, 32'h0000_00AA, $urandom, 0);
        checks++; if (ob_be !== 4'b1000) begin errors++; $display("FAIL be_sb_be got %b exp 1000", ob_be); end
        checks++; if (ob_wd !== 32'hAAAA_AAAA) begin errors++; $display("FAIL be_sb_wdata got %h exp aaaaaaaa", ob_wd); end
        checks++; if (ob_kind !== 2'b10) begin errors++; $display("FAIL be_sb_strobe got %b exp 10", ob_kind); end
        sel = 1'b0;
    endtask

    task automatic test_back_to_back;
        sel = 1'b0;
        run_access(1'b0, 2'b10, 1'b0, 32'h200, $urandom, 32'hCAFE_F00D, 0);
        checks++; if (ob_strobes !== 1 || ob_overlap !== 0 || ob_kind !== 2'b01) begin
            errors++; $display("FAIL b2b_lw got strobes=%0d overlap=%0d kind=%b exp 1 0 01", ob_strobes, ob_overlap, ob_kind); end
        checks++; if (ob_rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_lw_rdata got %h exp cafef00d", ob_rd); end
        run_access(1'b1, 2'b10, 1'b0, 32'h204, 32'h1357_9BDF, $urandom, 0);
        checks++; if (ob_strobes !== 1 || ob_overlap !== 0 || ob_kind !== 2'b10) begin
            errors++; $display("FAIL b2b_sw got strobes=%0d overlap=%0d kind=%b exp 1 0 10", ob_strobes, ob_overlap, ob_kind); end
        checks++; if (ob_lat !== 2) begin errors++; $display("FAIL b2b_sw_latency got %0d exp 2", ob_lat); end
    endtask

    task automatic test_random;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_rd, a, wd, rd, mask;
        logic [1:0]  e_err, sz, e_kind;
        logic        we, sg;
        int          w, el, es;
        for (int i = 0; i < 40; i++) begin
            sel = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a = $urandom & 32'h0000_FFFF; wd = $urandom; rd = $urandom;
            w = $urandom_range(0, 3);
            model(we, sz, sg, a, wd, rd, sel, e_be, e_wd, e_rd, e_err);
            run_access(we, sz, sg, a, wd, rd, w);
            mask   = {{8{e_be[3]}}, {8{e_be[2]}}, {8{e_be[1]}}, {8{e_be[0]}}};
            el     = (e_err != 2'b00) ? 1 : w + 2;
            es     = (e_err != 2'b00) ? 0 : 1;
            e_kind = (e_err != 2'b00) ? 2'b00 : (we ? 2'b10 : 2'b01);
            checks++; if (ob_be !== e_be) begin errors++; $display("FAIL rnd%0d_be got %b exp %b", i, ob_be, e_be); end
            checks++; if ((ob_wd & mask) !== e_wd) begin errors++; $display("FAIL rnd%0d_wdata got %h exp %h", i, ob_wd & mask, e_wd); end
            checks++; if (ob_rd !== e_rd) begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h", i, ob_rd, e_rd); end
            checks++; if (ob_err !== e_err) begin errors++; $display("FAIL rnd%0d_err got %b exp %b", i, ob_err, e_err); end
            checks++; if (ob_lat !== el) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, ob_lat, el); end
            checks++; if (ob_strobes !== es || ob_kind !== e_kind) begin
                errors++; $display("FAIL rnd%0d_strobe got %0d/%b exp %0d/%b", i, ob_strobes, ob_kind, es, e_kind); end
            checks++; if (ob_ad !== (es != 0 ? (a & ~32'h3) : 32'h0)) begin
                errors++; $display("FAIL rnd%0d_addr got %h exp %h", i, ob_ad, es != 0 ? (a & ~32'h3) : 32'h0); end
        end
        sel = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; sel = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        drive_mem(1'b0, 32'h0);
        test_reset;
        test_lb_signed;
        test_sh_waits;
        test_misaligned;
        test_timeout;
        test_async_reset;
        test_big_endian;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
